// File: rtl/panel_scan_ctrl.sv
// Scan sequencer for the 6-group multiplexed front-panel LED array.
// Each group slot runs a prescaled timer with a dead time, PWM brightness and frame-synchronous lamp snapshots.
module panel_scan_ctrl #(
   parameter int PRESCALE = 64,
   parameter int DEADTIME = 4
) (
   input  logic        CLK,
   input  logic        RESET,
   input  logic [11:0] green,
   input  logic [11:0] red,
   input  logic [11:0] yellow,
   input  logic [3:0]  BRIGHT,
   input  logic        FREEZE,
   output logic        GREEN1,
   output logic        GREEN2,
   output logic        RED1,
   output logic        RED2,
   output logic        YELLOW1,
   output logic        YELLOW2,
   output logic        PLED1,
   output logic        PLED2,
   output logic        PLED3,
   output logic        PLED4,
   output logic        PLED5,
   output logic        PLED6,
   output logic [2:0]  SLOT,
   output logic        FRAME
);

   localparam int            TW        = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
   localparam logic [TW-1:0] TICK_LAST = TW'(PRESCALE - 1);
   localparam logic [TW-1:0] DEAD      = TW'(DEADTIME);
   localparam logic [TW+3:0] SPAN      = (TW+4)'(PRESCALE - DEADTIME);

   logic [TW-1:0] tick, tick_next;
   logic [2:0]    slot, slot_next;
   logic [35:0]   shadow;
   logic [TW-1:0] onlen, onlen_calc;
   logic [TW+3:0] prod;
   logic          tick_wrap, slot_start, snap, lit;
   logic [5:0]    half, sel_next, pled_next;
   logic [5:0]    sel_q, pled_q;
   logic [2:0]    slot_q;
   logic          frame_q;

   assign slot_start = (tick == '0);
   assign tick_wrap  = (tick == TICK_LAST);
   assign snap       = slot_start && (slot == 3'd0);

   // The product is at most SPAN*16, which always fits in TW+4 bits.
   assign prod       = SPAN * (TW+4)'({1'b0, BRIGHT} + 5'd1);
   assign onlen_calc = TW'(prod >> 4);

   // NOTE: every variable gets a default first, so no path can leave it unassigned and infer a latch.
   always_comb begin
      tick_next = tick_wrap ? '0 : tick + TW'(1);
      slot_next = slot;
      if (tick_wrap) begin
         slot_next = (slot == 3'd5) ? 3'd0 : slot + 3'd1;
      end
   end

   // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge CLK) begin
      if (RESET) begin
         tick   <= '0;
         slot   <= 3'd0;
         shadow <= '0;
         onlen  <= '0;
      end else begin
         tick <= tick_next;
         slot <= slot_next;
         if (slot_start) begin
            onlen <= onlen_calc;
         end
         if (snap && !FREEZE) begin
            shadow <= {yellow, red, green};
         end
      end
   end

   // Tick 0 is always in the dead window, so the onlen latched there governs the whole slot.
   assign lit = (tick >= DEAD) && ((tick - DEAD) < onlen);

   always_comb begin
      half = '0;
      unique case (slot)
         3'd0:    half = shadow[5:0];
         3'd1:    half = shadow[11:6];
         3'd2:    half = shadow[17:12];
         3'd3:    half = shadow[23:18];
         3'd4:    half = shadow[29:24];
         3'd5:    half = shadow[35:30];
         default: half = '0;
      endcase
   end

   always_comb begin
      sel_next  = lit ? (6'b000001 << slot) : 6'b000000;
      pled_next = lit ? half : 6'b000000;
   end

   always_ff @(posedge CLK) begin
      if (RESET) begin
         sel_q   <= '0;
         pled_q  <= '0;
         slot_q  <= 3'd0;
         frame_q <= 1'b0;
      end else begin
         sel_q   <= sel_next;
         pled_q  <= pled_next;
         slot_q  <= slot;
         frame_q <= snap;
      end
   end

   assign {YELLOW2, YELLOW1, RED2, RED1, GREEN2, GREEN1} = sel_q;
   assign {PLED6, PLED5, PLED4, PLED3, PLED2, PLED1}     = pled_q;
   assign SLOT  = slot_q;
   assign FRAME = frame_q;

   a_one_select : assert property (@(posedge CLK) disable iff (RESET) $onehot0(sel_q));
   a_no_orphan  : assert property (@(posedge CLK) disable iff (RESET) (|pled_q) |-> (|sel_q));
   a_slot_range : assert property (@(posedge CLK) disable iff (RESET) slot <= 3'd5);

endmodule

// File: tb/tb_panel_scan_ctrl.sv
// Directed bench for panel_scan_ctrl: a small-timing instance (8/2) for exact frames
// and a default-parameter instance for a long randomised safety run.
module tb_panel_scan_ctrl;

   logic        CLK = 1'b0;
   logic        RESET;
   logic [11:0] green, red, yellow;
   logic [3:0]  BRIGHT;
   logic        FREEZE;

   logic a_g1, a_g2, a_r1, a_r2, a_y1, a_y2, a_p1, a_p2, a_p3, a_p4, a_p5, a_p6, a_frame;
   logic b_g1, b_g2, b_r1, b_r2, b_y1, b_y2, b_p1, b_p2, b_p3, b_p4, b_p5, b_p6, b_frame;
   logic [2:0] a_slot, b_slot;

   wire [5:0] a_sel  = {a_y2, a_y1, a_r2, a_r1, a_g2, a_g1};
   wire [5:0] a_pled = {a_p6, a_p5, a_p4, a_p3, a_p2, a_p1};
   wire [5:0] b_sel  = {b_y2, b_y1, b_r2, b_r1, b_g2, b_g1};
   wire [5:0] b_pled = {b_p6, b_p5, b_p4, b_p3, b_p2, b_p1};
   wire [15:0] a_word = {a_sel, a_pled, a_slot, a_frame};

   int checks = 0;
   int errors = 0;

   logic [15:0] cap [48];
   int          last_wait;

   // Per-slot lamp patterns, slot 5 leftmost.
   localparam logic [5:0][5:0] PAT_A = {6'b100000, 6'b000000, 6'b000000, 6'b000001, 6'b111000, 6'b111000};
   localparam logic [5:0][5:0] PAT_B = {6'b100000, 6'b000000, 6'b000000, 6'b000001, 6'b000111, 6'b000111};
   localparam logic [5:0][5:0] PAT_C = {6'b000000, 6'b000000, 6'b111111, 6'b111111, 6'b111000, 6'b111000};
   localparam logic [5:0][3:0] ONS_6   = {4'd6, 4'd6, 4'd6, 4'd6, 4'd6, 4'd6};
   localparam logic [5:0][3:0] ONS_3   = {4'd3, 4'd3, 4'd3, 4'd3, 4'd3, 4'd3};
   localparam logic [5:0][3:0] ONS_0   = {4'd0, 4'd0, 4'd0, 4'd0, 4'd0, 4'd0};
   localparam logic [5:0][3:0] ONS_MIX = {4'd6, 4'd6, 4'd6, 4'd6, 4'd0, 4'd0};

   panel_scan_ctrl #(.PRESCALE(8), .DEADTIME(2)) dut (
      .CLK(CLK), .RESET(RESET), .green(green), .red(red), .yellow(yellow),
      .BRIGHT(BRIGHT), .FREEZE(FREEZE),
      .GREEN1(a_g1), .GREEN2(a_g2), .RED1(a_r1), .RED2(a_r2), .YELLOW1(a_y1), .YELLOW2(a_y2),
      .PLED1(a_p1), .PLED2(a_p2), .PLED3(a_p3), .PLED4(a_p4), .PLED5(a_p5), .PLED6(a_p6),
      .SLOT(a_slot), .FRAME(a_frame)
   );

   panel_scan_ctrl dut_d (
      .CLK(CLK), .RESET(RESET), .green(green), .red(red), .yellow(yellow),
      .BRIGHT(BRIGHT), .FREEZE(FREEZE),
      .GREEN1(b_g1), .GREEN2(b_g2), .RED1(b_r1), .RED2(b_r2), .YELLOW1(b_y1), .YELLOW2(b_y2),
      .PLED1(b_p1), .PLED2(b_p2), .PLED3(b_p3), .PLED4(b_p4), .PLED5(b_p5), .PLED6(b_p6),
      .SLOT(b_slot), .FRAME(b_frame)
   );

   always #5 CLK = ~CLK;

   initial begin
      #2_000_000;
      $display("FAIL watchdog expired");
      $fatal(1, "watchdog");
   end

   task automatic step();
      @(posedge CLK);
      #1;
   endtask

   // Expected sample k of a frame on the 8/2 instance; sample 0 carries the FRAME pulse.
   function automatic logic [15:0] exp_word(int k, logic [5:0][3:0] ons, logic [5:0][5:0] pat);
      int         s = k / 8;
      int         t = k % 8;
      logic       lit;
      logic [5:0] sel, pl;
      lit = (t >= 2) && ((t - 2) < int'(ons[s]));
      sel = lit ? 6'(1 << s) : 6'd0;
      pl  = lit ? pat[s] : 6'd0;
      return {sel, pl, 3'(s), (k == 0)};
   endfunction

   // Waits for the next FRAME pulse then records 48 samples; optional input change after sample chg_at.
   task automatic capture(input int chg_at, input logic [11:0] chg_green, input logic [3:0] chg_bright);
      int n;
      step();
      n = 1;
      while (a_frame !== 1'b1 && n < 100) begin
         step();
         n++;
      end
      last_wait = n;
      if (a_frame !== 1'b1) begin
         checks++;
         errors++;
         $display("FAIL frame_timeout got FRAME=%b after %0d cycles", a_frame, n);
      end
      for (int k = 0; k < 48; k++) begin
         if (k > 0) step();
         cap[k] = a_word;
         if (k == chg_at) begin
            green  = chg_green;
            BRIGHT = chg_bright;
         end
      end
   endtask

   task automatic test_reset();
      RESET = 1'b1;
      repeat (3) step();
      checks++;
      if (a_word !== 16'h0000) begin
         errors++;
         $display("FAIL reset_outputs got %h exp 0000", a_word);
      end
      RESET = 1'b0;
      step();
      checks++;
      if (a_word !== 16'h0001) begin
         errors++;
         $display("FAIL reset_first_frame got %h exp 0001", a_word);
      end
      repeat (27) step();
      checks++;
      if (a_word !== {6'b001000, 6'b000000, 3'd3, 1'b0}) begin
         errors++;
         $display("FAIL midframe_slot3 got %h exp %h", a_word, {6'b001000, 6'b000000, 3'd3, 1'b0});
      end
      RESET = 1'b1;
      for (int i = 0; i < 3; i++) begin
         step();
         checks++;
         if (a_word !== 16'h0000) begin
            errors++;
            $display("FAIL midframe_reset_%0d got %h exp 0000", i, a_word);
         end
      end
      RESET = 1'b0;
      step();
      checks++;
      if (a_word !== 16'h0001) begin
         errors++;
         $display("FAIL release_frame got %h exp 0001", a_word);
      end
      step();
      checks++;
      if (a_word !== 16'h0000) begin
         errors++;
         $display("FAIL release_frame_width got %h exp 0000", a_word);
      end
   endtask

   task automatic test_full_brightness();
      capture(-1, 12'o7070, 4'd15);
      for (int k = 0; k < 48; k++) begin
         checks++;
         if (cap[k] !== exp_word(k, ONS_6, PAT_A)) begin
            errors++;
            $display("FAIL full_k%0d got %h exp %h", k, cap[k], exp_word(k, ONS_6, PAT_A));
         end
      end
      capture(-1, 12'o7070, 4'd15);
      checks++;
      if (last_wait !== 1) begin
         errors++;
         $display("FAIL frame_spacing got %0d exp 48", 47 + last_wait);
      end
   endtask

   task automatic test_brightness();
      BRIGHT = 4'd7;
      capture(-1, 12'o7070, 4'd7);
      for (int k = 0; k < 48; k++) begin
         checks++;
         if (cap[k] !== exp_word(k, ONS_3, PAT_A)) begin
            errors++;
            $display("FAIL bright7_k%0d got %h exp %h", k, cap[k], exp_word(k, ONS_3, PAT_A));
         end
      end
      BRIGHT = 4'd0;
      capture(-1, 12'o7070, 4'd0);
      for (int k = 0; k < 48; k++) begin
         checks++;
         if (cap[k] !== exp_word(k, ONS_0, PAT_A)) begin
            errors++;
            $display("FAIL bright0_k%0d got %h exp %h", k, cap[k], exp_word(k, ONS_0, PAT_A));
         end
      end
      // Raised in the middle of slot 1: slot 1 stays dark, slot 2 onwards is full.
      capture(11, 12'o7070, 4'd15);
      for (int k = 0; k < 48; k++) begin
         checks++;
         if (cap[k] !== exp_word(k, ONS_MIX, PAT_A)) begin
            errors++;
            $display("FAIL bright_midslot_k%0d got %h exp %h", k, cap[k], exp_word(k, ONS_MIX, PAT_A));
         end
      end
   endtask

   task automatic test_snapshot();
      capture(20, 12'o0707, 4'd15);
      for (int k = 0; k < 48; k++) begin
         checks++;
         if (cap[k] !== exp_word(k, ONS_6, PAT_A)) begin
            errors++;
            $display("FAIL snap_old_k%0d got %h exp %h", k, cap[k], exp_word(k, ONS_6, PAT_A));
         end
      end
      capture(-1, 12'o0707, 4'd15);
      for (int k = 0; k < 48; k++) begin
         checks++;
         if (cap[k] !== exp_word(k, ONS_6, PAT_B)) begin
            errors++;
            $display("FAIL snap_new_k%0d got %h exp %h", k, cap[k], exp_word(k, ONS_6, PAT_B));
         end
      end
   endtask

   task automatic test_freeze();
      FREEZE = 1'b1;
      green  = 12'o7070;
      red    = 12'o7777;
      yellow = 12'o0000;
      for (int f = 0; f < 3; f++) begin
         capture(-1, 12'o7070, 4'd15);
         for (int k = 0; k < 48; k++) begin
            checks++;
            if (cap[k] !== exp_word(k, ONS_6, PAT_B)) begin
               errors++;
               $display("FAIL freeze_f%0d_k%0d got %h exp %h", f, k, cap[k], exp_word(k, ONS_6, PAT_B));
            end
         end
      end
      FREEZE = 1'b0;
      capture(-1, 12'o7070, 4'd15);
      for (int k = 0; k < 48; k++) begin
         checks++;
         if (cap[k] !== exp_word(k, ONS_6, PAT_C)) begin
            errors++;
            $display("FAIL unfreeze_k%0d got %h exp %h", k, cap[k], exp_word(k, ONS_6, PAT_C));
         end
      end
   endtask

   // Default instance (64/4): one comparison per frame of accumulated rule violations.
   task automatic test_exclusivity();
      int n;
      int bad;
      n = 0;
      while (b_frame !== 1'b1 && n < 400) begin
         step();
         n++;
      end
      checks++;
      if (b_frame !== 1'b1) begin
         errors++;
         $display("FAIL default_frame_timeout got FRAME=%b after %0d cycles", b_frame, n);
         return;
      end
      for (int f = 0; f < 100; f++) begin
         bad = 0;
         for (int k = 0; k < 384; k++) begin
            if (!(f == 0 && k == 0)) step();
            if (!$onehot0(b_sel)) bad++;
            if (b_sel !== 6'd0 && b_sel !== 6'(1 << (k / 64))) bad++;
            if (b_pled !== 6'd0 && b_sel === 6'd0) bad++;
            if ((k % 64) < 4 && (b_sel !== 6'd0 || b_pled !== 6'd0)) bad++;
            if (b_slot !== 3'(k / 64)) bad++;
            if (b_frame !== (k == 0)) bad++;
            if ($urandom_range(0, 31) == 0) begin
               green  = 12'($urandom);
               red    = 12'($urandom);
               yellow = 12'($urandom);
               BRIGHT = 4'($urandom);
            end
         end
         checks++;
         if (bad != 0) begin
            errors++;
            $display("FAIL exclusivity_frame%0d got %0d violations exp 0", f, bad);
         end
      end
   endtask

   initial begin
      RESET  = 1'b1;
      green  = 12'o7070;
      red    = 12'o0001;
      yellow = 12'o4000;
      BRIGHT = 4'd15;
      FREEZE = 1'b0;
      test_reset();
      test_full_brightness();
      test_brightness();
      test_snapshot();
      test_freeze();
      test_exclusivity();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
